// File: rtl/rvh_l1d_amo_pkg.sv
// Shared types and constants for the L1D AMO execution pipeline.
package rvh_l1d_amo_pkg;

    localparam int unsigned AMO_OP_W = 5;

    typedef enum logic [AMO_OP_W-1:0] {
        AMO_ADD  = 5'd0,
        AMO_SWAP = 5'd1,
        AMO_AND  = 5'd2,
        AMO_OR   = 5'd3,
        AMO_XOR  = 5'd4,
        AMO_MIN  = 5'd5,
        AMO_MAX  = 5'd6,
        AMO_MINU = 5'd7,
        AMO_MAXU = 5'd8
    } amo_op_e;

    localparam logic [7:0] WMASK_LO = 8'h0F;
    localparam logic [7:0] WMASK_HI = 8'hF0;
    localparam logic [7:0] DMASK    = 8'hFF;

    // Stage-1 payload; datapath is fixed at 64 bits.
    typedef struct packed {
        logic        op_w;
        logic        addr_off;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] sum;
        logic [63:0] and_r;
        logic [63:0] or_r;
        logic [63:0] xor_r;
        logic        lt_s;
        logic        lt_u;
    } amo_s1_t;

endpackage

// File: rtl/rvh_l1d_amo_cmp.sv
// Adder plus single 65-bit subtractor; the borrow gives the signed or unsigned less-than.
module rvh_l1d_amo_cmp #(
    parameter int unsigned XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            is_signed,
    output logic [XLEN-1:0] sum,
    output logic            lt_s,
    output logic            lt_u
);

    logic [XLEN:0] a_ext;
    logic [XLEN:0] b_ext;
    logic [XLEN:0] diff;

    always_comb begin
        a_ext = {is_signed & a[XLEN-1], a};
        b_ext = {is_signed & b[XLEN-1], b};
        diff  = a_ext - b_ext;
        sum   = a + b;
        lt_s  = is_signed & diff[XLEN];
        lt_u  = ~is_signed & diff[XLEN];
    end

endmodule

// File: rtl/rvh_l1d_amo_alu_pipe.sv
// Two-stage RV64A AMO ALU: operand prep/compare in stage 1, result select and
// write-mask/rd formatting in stage 2, valid/ready with flush.
module rvh_l1d_amo_alu_pipe
    import rvh_l1d_amo_pkg::*;
#(
    parameter int unsigned XLEN         = 64,
    parameter int unsigned ALU_OP_WIDTH = 5,
    parameter int unsigned TAG_WIDTH    = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    flush_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [ALU_OP_WIDTH-1:0] in_opcode_i,
    input  logic                    in_op_w_i,
    input  logic                    in_addr_off_i,
    input  logic [XLEN-1:0]         in_mem_data_i,
    input  logic [XLEN-1:0]         in_rs2_i,
    input  logic [TAG_WIDTH-1:0]    in_tag_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [TAG_WIDTH-1:0]    out_tag_o,
    output logic [XLEN-1:0]         out_wdata_o,
    output logic [XLEN/8-1:0]       out_wmask_o,
    output logic [XLEN-1:0]         out_rd_data_o
);

    logic                    s1_valid;
    amo_s1_t                 s1_d;
    amo_s1_t                 s1_q;
    logic [ALU_OP_WIDTH-1:0] s1_op;
    logic [TAG_WIDTH-1:0]    s1_tag;
    logic                    adv2;
    logic                    accept;

    logic                    is_signed;
    logic [31:0]             a_half;
    logic [XLEN-1:0]         a_in;
    logic [XLEN-1:0]         b_in;
    logic [XLEN-1:0]         sum;
    logic                    lt_s;
    logic                    lt_u;

    always_comb begin
        adv2       = ~out_valid_o | out_ready_i;
        in_ready_o = ~s1_valid | adv2;
        accept     = in_valid_i & in_ready_o;
    end

    // W ops widen the selected half so the 64-bit compare yields the 32-bit ordering.
    always_comb begin
        is_signed = (in_opcode_i == ALU_OP_WIDTH'(AMO_MIN)) ||
                    (in_opcode_i == ALU_OP_WIDTH'(AMO_MAX));
        a_half    = in_addr_off_i ? in_mem_data_i[63:32] : in_mem_data_i[31:0];
        if (in_op_w_i) begin
            a_in = {{32{is_signed & a_half[31]}}, a_half};
            b_in = {{32{is_signed & in_rs2_i[31]}}, in_rs2_i[31:0]};
        end else begin
            a_in = in_mem_data_i;
            b_in = in_rs2_i;
        end
    end

    rvh_l1d_amo_cmp #(
        .XLEN(XLEN)
    ) u_cmp (
        .a         (a_in),
        .b         (b_in),
        .is_signed (is_signed),
        .sum       (sum),
        .lt_s      (lt_s),
        .lt_u      (lt_u)
    );

    always_comb begin
        s1_d.op_w     = in_op_w_i;
        s1_d.addr_off = in_addr_off_i;
        s1_d.a        = a_in;
        s1_d.b        = b_in;
        s1_d.sum      = sum;
        s1_d.and_r    = a_in & b_in;
        s1_d.or_r     = a_in | b_in;
        s1_d.xor_r    = a_in ^ b_in;
        s1_d.lt_s     = lt_s;
        s1_d.lt_u     = lt_u;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_op    <= '0;
            s1_tag   <= '0;
        end else begin
            if (flush_i) begin
                s1_valid <= 1'b0;
            end else if (in_ready_o) begin
                s1_valid <= in_valid_i;
            end
            if (accept) begin
                s1_q   <= s1_d;
                s1_op  <= in_opcode_i;
                s1_tag <= in_tag_i;
            end
        end
    end

    logic [XLEN-1:0]   s2_res;
    logic              s2_known;
    logic [XLEN-1:0]   s2_wdata;
    logic [XLEN/8-1:0] s2_wmask;
    logic [XLEN-1:0]   s2_rd;

    always_comb begin
        s2_res   = s1_q.a;
        s2_known = 1'b1;
        case (s1_op)
            ALU_OP_WIDTH'(AMO_ADD):  s2_res = s1_q.sum;
            ALU_OP_WIDTH'(AMO_SWAP): s2_res = s1_q.b;
            ALU_OP_WIDTH'(AMO_AND):  s2_res = s1_q.and_r;
            ALU_OP_WIDTH'(AMO_OR):   s2_res = s1_q.or_r;
            ALU_OP_WIDTH'(AMO_XOR):  s2_res = s1_q.xor_r;
            ALU_OP_WIDTH'(AMO_MIN):  s2_res = s1_q.lt_s ? s1_q.a : s1_q.b;
            ALU_OP_WIDTH'(AMO_MAX):  s2_res = s1_q.lt_s ? s1_q.b : s1_q.a;
            ALU_OP_WIDTH'(AMO_MINU): s2_res = s1_q.lt_u ? s1_q.a : s1_q.b;
            ALU_OP_WIDTH'(AMO_MAXU): s2_res = s1_q.lt_u ? s1_q.b : s1_q.a;
            default: begin
                s2_res   = s1_q.a;
                s2_known = 1'b0;
            end
        endcase
        if (s1_q.op_w) begin
            s2_wdata = {s2_res[31:0], s2_res[31:0]};
            s2_wmask = s1_q.addr_off ? WMASK_HI : WMASK_LO;
            s2_rd    = {{32{s1_q.a[31]}}, s1_q.a[31:0]};
        end else begin
            s2_wdata = s2_res;
            s2_wmask = DMASK;
            s2_rd    = s1_q.a;
        end
        if (!s2_known) begin
            s2_wmask = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_o   <= 1'b0;
            out_tag_o     <= '0;
            out_wdata_o   <= '0;
            out_wmask_o   <= '0;
            out_rd_data_o <= '0;
        end else begin
            if (flush_i) begin
                out_valid_o <= 1'b0;
            end else if (adv2) begin
                out_valid_o <= s1_valid;
            end
            if (adv2 && s1_valid) begin
                out_tag_o     <= s1_tag;
                out_wdata_o   <= s2_wdata;
                out_wmask_o   <= s2_wmask;
                out_rd_data_o <= s2_rd;
            end
        end
    end

endmodule
